// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states, halt causes and ALU function codes shared by cpu_mc
package cpu_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [1:0] HC_NONE     = 2'b00;
    localparam logic [1:0] HC_ILLEGAL  = 2'b01;
    localparam logic [1:0] HC_MISALIGN = 2'b10;
    localparam logic [1:0] HC_ECALL    = 2'b11;

    // ALU function code is {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction
endpackage

// File: rtl/cpu_mc_if.sv
// cpu_mc_if: instruction and data memory request/valid bus of cpu_mc
interface cpu_mc_if;
    logic [31:0] iaddr, idata, daddr, dwdata, drdata;
    logic        ireq, ivalid, dreq, dvalid;
    logic [3:0]  dwe;
    modport master (output iaddr, ireq, daddr, dwdata, dwe, dreq, input idata, ivalid, drdata, dvalid);
    modport slave  (input iaddr, ireq, daddr, dwdata, dwe, dreq, output idata, ivalid, drdata, dvalid);
endinterface

// File: rtl/cpu_mc_regfile_n.sv
// regfile_n: NREGS x 32 register file, two combinational reads, one synchronous write, x0 stays zero
module regfile_n #(
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic                     we,
    input  logic [31:0]              wd,
    output logic [31:0]              rd1,
    output logic [31:0]              rd2
);
    logic [31:0] regs [NREGS];
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
    // Clear everything on reset; x0 is never written so it always reads zero
    always_ff @(posedge clk)
        if (!reset) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        else if (we && wa != '0) regs[wa] <= wd;
endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle RV32I/RV32E core; define CPU_MC_MISALIGN_TRAP_EN to trap misaligned accesses/targets
module cpu_mc import cpu_pkg::*; #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          NREGS        = 32
) (
    input  logic           clk,
    input  logic           reset,
    cpu_mc_if.master       bus,
    output logic           retire,
    output logic           halted,
    output logic [1:0]     halt_cause
);
    localparam int AW = $clog2(NREGS);
    state_t      state;
    logic [31:0] pc, ir, daddr, dwdata;
    logic [3:0]  dwe;
    logic        ireq, dreq;
    assign bus.iaddr  = pc;
    assign bus.ireq   = ireq;
    assign bus.daddr  = daddr;
    assign bus.dwdata = dwdata;
    assign bus.dwe    = dwe;
    assign bus.dreq   = dreq;

    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rv1, rv2, ea, ea_al, npc, wb_exec, st_data, ld_sh, ld_val, wd;
    logic [3:0]  st_we;
    logic        is_load, is_store, is_mem, uses_rs1, uses_rs2, uses_rd, legal, is_sys, bad_idx, taken, misalign, we;
    logic [1:0]  cause;

    assign opc   = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign f7    = ir[31:25];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    regfile_n #(.NREGS(NREGS)) u_rf (
        .clk(clk), .reset(reset), .ra1(ir[15 +: AW]), .ra2(ir[20 +: AW]), .wa(ir[7 +: AW]),
        .we(we), .wd(wd), .rd1(rv1), .rd2(rv2)
    );

    assign is_load  = opc == OP_LOAD;
    assign is_store = opc == OP_STORE;
    assign is_mem   = is_load || is_store;
    assign is_sys   = opc == OP_SYSTEM && (ir[31:7] == 25'h0 || ir[31:7] == 25'h0002000);
    assign uses_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign uses_rs2 = opc == OP_BRANCH || is_store || opc == OP_REG;
    assign uses_rd  = !(opc == OP_BRANCH || is_store || opc == OP_SYSTEM);
    assign bad_idx  = (uses_rs1 && 32'(rs1) >= NREGS) || (uses_rs2 && 32'(rs2) >= NREGS) || (uses_rd && 32'(rd) >= NREGS);

    // Opcode and funct3/funct7 legality
    always_comb begin
        legal = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
            OP_JALR:   legal = f3 == 3'b000;
            OP_BRANCH: legal = f3[2:1] != 2'b01;
            OP_LOAD:   legal = f3 != 3'b011 && f3[2:1] != 2'b11;
            OP_STORE:  legal = !f3[2] && f3[1:0] != 2'b11;
            OP_IMM:    legal = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 & 7'b1011111) == 7'h00 : 1'b1;
            OP_REG:    legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            OP_SYSTEM: legal = is_sys;
            default:   legal = 1'b0;
        endcase
    end

    assign taken   = (f3[2] ? (f3[1] ? rv1 < rv2 : $signed(rv1) < $signed(rv2)) : rv1 == rv2) ^ f3[0];
    assign npc     = opc == OP_JAL ? pc + imm_j : opc == OP_JALR ? (rv1 + imm_i) & ~32'd1 :
                     opc == OP_BRANCH && taken ? pc + imm_b : pc + 32'd4;
    assign wb_exec = opc == OP_LUI ? imm_u : opc == OP_AUIPC ? pc + imm_u :
                     opc == OP_JAL || opc == OP_JALR ? pc + 32'd4 :
                     alu({(opc == OP_REG || f3 == 3'b101) && f7[5], f3}, rv1, opc == OP_REG ? rv2 : imm_i);
    assign ea      = rv1 + (is_store ? imm_s : imm_i);
`ifdef CPU_MC_MISALIGN_TRAP_EN
    assign ea_al    = ea;
    assign misalign = (is_mem && (f3[1:0] == 2'b01 ? ea[0] : f3[1:0] == 2'b10 ? |ea[1:0] : 1'b0)) ||
                      ((opc == OP_JAL || opc == OP_JALR || (opc == OP_BRANCH && taken)) && npc[1]);
`else
    assign ea_al    = f3[1] ? {ea[31:2], 2'b00} : f3[0] ? {ea[31:1], 1'b0} : ea;
    assign misalign = 1'b0;
`endif
    assign cause   = !legal || bad_idx ? HC_ILLEGAL : is_sys ? HC_ECALL : misalign ? HC_MISALIGN : HC_NONE;
    assign st_we   = f3[1] ? 4'b1111 : f3[0] ? 4'b0011 << ea_al[1:0] : 4'b0001 << ea_al[1:0];
    assign st_data = rv2 << {ea_al[1:0], 3'b000};
    assign ld_sh   = bus.drdata >> {daddr[1:0], 3'b000};
    assign ld_val  = f3[1:0] == 2'b00 ? {{24{!f3[2] && ld_sh[7]}}, ld_sh[7:0]} :
                     f3[1:0] == 2'b01 ? {{16{!f3[2] && ld_sh[15]}}, ld_sh[15:0]} : ld_sh;
    assign we      = (state == S_EXEC && cause == HC_NONE && !is_mem && uses_rd) ||
                     (state == S_MEM && dreq && bus.dvalid && is_load);
    assign wd      = state == S_MEM ? ld_val : wb_exec;

    // Control FSM with registered bus and status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= RESET_VECTOR;
            ir         <= '0;
            ireq       <= 1'b0;
            dreq       <= 1'b0;
            dwe        <= '0;
            daddr      <= '0;
            dwdata     <= '0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            halt_cause <= HC_NONE;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (ireq && bus.ivalid) begin
                        ir    <= bus.idata;
                        ireq  <= 1'b0;
                        state <= S_EXEC;
                    end else ireq <= 1'b1;
                end
                S_EXEC: begin
                    if (cause != HC_NONE) begin
                        halted     <= 1'b1;
                        halt_cause <= cause;
                        state      <= S_HALT;
                    end else if (is_mem) begin
                        daddr  <= ea_al;
                        dwdata <= st_data;
                        dwe    <= is_store ? st_we : 4'b0000;
                        dreq   <= 1'b1;
                        state  <= S_MEM;
                    end else begin
                        pc     <= npc;
                        retire <= 1'b1;
                        ireq   <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dreq && bus.dvalid) begin
                        dreq   <= 1'b0;
                        dwe    <= '0;
                        pc     <= pc + 32'd4;
                        retire <= 1'b1;
                        ireq   <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                default: begin
                    ireq <= 1'b0;
                    dreq <= 1'b0;
                    dwe  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed bench for cpu_mc with small instruction/data memory models
module tb_cpu_mc;
    logic clk = 1'b0;
    logic reset, rst_b;
    logic retire_a, halted_a, retire_b, halted_b;
    logic [1:0] cause_a, cause_b;
    int vectors = 0, errs = 0, dwait = 0, dcnt = 0, n, rcount;
    logic [31:0] imem [256];
    logic [31:0] dmem [16];
    logic [31:0] imem_b [4];

    always #5 clk = ~clk;

    cpu_mc_if ifa();
    cpu_mc_if ifb();

    cpu_mc #(.RESET_VECTOR(32'h100), .NREGS(32)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa), .retire(retire_a), .halted(halted_a), .halt_cause(cause_a));
    cpu_mc #(.RESET_VECTOR(32'h0), .NREGS(16)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ifb), .retire(retire_b), .halted(halted_b), .halt_cause(cause_b));

    assign ifa.ivalid = ifa.ireq;
    assign ifa.idata  = imem[ifa.iaddr[9:2]];
    assign ifa.dvalid = ifa.dreq && dcnt >= dwait;
    assign ifa.drdata = dmem[ifa.daddr[5:2]];
    assign ifb.ivalid = ifb.ireq;
    assign ifb.idata  = imem_b[ifb.iaddr[3:2]];
    assign ifb.dvalid = 1'b0;
    assign ifb.drdata = 32'h0;

    always @(posedge clk) dcnt <= (!ifa.dreq || ifa.dvalid) ? 0 : dcnt + 1;
    always @(posedge clk)
        if (ifa.dreq && ifa.dvalid)
            for (int i = 0; i < 4; i++)
                if (ifa.dwe[i]) dmem[ifa.daddr[5:2]][8*i +: 8] <= ifa.dwdata[8*i +: 8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_retire(input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!retire_a && k < 50);
        check({tag, " retire"}, 32'(retire_a), 32'd1);
    endtask

    task automatic wait_dreq(input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!ifa.dreq && k < 50);
        check({tag, " dreq"}, 32'(ifa.dreq), 32'd1);
    endtask

    task automatic wait_halt(input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!halted_a && k < 50);
        check({tag, " halted"}, 32'(halted_a), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h00000013;
        imem[64] = 32'h00500093; // 100 ADDI x1,x0,5
        imem[65] = 32'h00108133; // 104 ADD  x2,x1,x1
        imem[66] = 32'h00202223; // 108 SW   x2,4(x0)
        imem[67] = 32'h00402183; // 10C LW   x3,4(x0)
        imem[68] = 32'h00302423; // 110 SW   x3,8(x0)
        imem[69] = 32'h0A500213; // 114 ADDI x4,x0,0xA5
        imem[70] = 32'h004001A3; // 118 SB   x4,3(x0)
        imem[71] = 32'h00300283; // 11C LB   x5,3(x0)
        imem[72] = 32'h00304303; // 120 LBU  x6,3(x0)
        imem[73] = 32'h00502623; // 124 SW   x5,12(x0)
        imem[74] = 32'h00602823; // 128 SW   x6,16(x0)
        imem[75] = 32'h00208463; // 12C BEQ  x1,x2,+8 (not taken)
        imem[76] = 32'h00310463; // 130 BEQ  x2,x3,+8 (taken)
        imem[77] = 32'h00100393; // 134 ADDI x7,x0,1 (skipped)
        imem[78] = 32'h0100046F; // 138 JAL  x8,+16
        imem[82] = 32'h20300493; // 148 ADDI x9,x0,0x203
        imem[83] = 32'h00048567; // 14C JALR x10,0(x9)
        imem[128] = 32'h00802A23; // 200 SW  x8,20(x0)
        imem[129] = 32'h00A02C23; // 204 SW  x10,24(x0)
        imem[130] = 32'h00000073; // 208 ECALL
        imem_b[0] = 32'h00100093; // ADDI x1,x0,1
        imem_b[1] = 32'h002088B3; // ADD x17,x1,x2
        imem_b[2] = 32'h00000013;
        imem_b[3] = 32'h00000013;
        reset = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst iaddr", ifa.iaddr, 32'h100);
        check("rst ireq", 32'(ifa.ireq), 0);
        check("rst dreq", 32'(ifa.dreq), 0);
        check("rst retire", 32'(retire_a), 0);
        check("rst halted", 32'(halted_a), 0);
        check("rst dwe", 32'(ifa.dwe), 0);
        check("rst daddr", ifa.daddr, 0);
        check("rst dwdata", ifa.dwdata, 0);
        check("rst cause", 32'(cause_a), 0);
        reset = 1'b1;
        @(negedge clk);
        check("first ireq", 32'(ifa.ireq), 1);
        check("first iaddr", ifa.iaddr, 32'h100);
        @(negedge clk);
        check("addi exec ireq", 32'(ifa.ireq), 0);
        check("addi exec retire", 32'(retire_a), 0);
        @(negedge clk);
        check("addi retire", 32'(retire_a), 1);
        check("addi npc", ifa.iaddr, 32'h104);
        @(negedge clk);
        check("add fetch retire", 32'(retire_a), 0);
        @(negedge clk);
        check("add retire", 32'(retire_a), 1);
        check("add npc", ifa.iaddr, 32'h108);
        dwait = 3;
        @(negedge clk);
        check("sw exec dreq", 32'(ifa.dreq), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sw stall dreq", 32'(ifa.dreq), 1);
            check("sw stall daddr", ifa.daddr, 32'h4);
            check("sw stall dwdata", ifa.dwdata, 32'd10);
            check("sw stall dwe", 32'(ifa.dwe), 32'hF);
            check("sw stall retire", 32'(retire_a), 0);
        end
        @(negedge clk);
        check("sw retire", 32'(retire_a), 1);
        check("sw dreq drop", 32'(ifa.dreq), 0);
        check("sw npc", ifa.iaddr, 32'h10C);
        check("sw mem", dmem[1], 32'd10);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lw stall dreq", 32'(ifa.dreq), 1);
            check("lw stall daddr", ifa.daddr, 32'h4);
            check("lw stall dwe", 32'(ifa.dwe), 0);
        end
        @(negedge clk);
        check("lw retire", 32'(retire_a), 1);
        check("lw npc", ifa.iaddr, 32'h110);
        dwait = 0;
        wait_dreq("sw x3");
        check("sw x3 daddr", ifa.daddr, 32'h8);
        check("sw x3 data", ifa.dwdata, 32'd10);
        wait_dreq("sb");
        check("sb daddr", ifa.daddr, 32'h3);
        check("sb dwe", 32'(ifa.dwe), 32'h8);
        check("sb dwdata", ifa.dwdata, 32'hA500_0000);
        wait_dreq("lb");
        check("lb dwe", 32'(ifa.dwe), 0);
        check("sb mem byte", 32'(dmem[0][31:24]), 32'hA5);
        wait_dreq("lbu");
        wait_dreq("sw x5");
        check("lb value", ifa.dwdata, 32'hFFFF_FFA5);
        wait_dreq("sw x6");
        check("lbu value", ifa.dwdata, 32'h0000_00A5);
        wait_retire("sw x6");
        check("beq1 pc", ifa.iaddr, 32'h12C);
        wait_retire("beq nt");
        check("beq nt pc", ifa.iaddr, 32'h130);
        wait_retire("beq t");
        check("beq t pc", ifa.iaddr, 32'h138);
        wait_retire("jal");
        check("jal pc", ifa.iaddr, 32'h148);
        wait_retire("addi x9");
        check("jalr at", ifa.iaddr, 32'h14C);
`ifdef CPU_MC_MISALIGN_TRAP_EN
        wait_halt("jalr misalign");
        check("jalr cause", 32'(cause_a), 32'h2);
        check("jalr halt ireq", 32'(ifa.ireq), 0);
`else
        wait_retire("jalr");
        check("jalr pc", ifa.iaddr, 32'h202);
        wait_dreq("sw x8");
        check("jal link", ifa.dwdata, 32'h13C);
        check("sw x8 daddr", ifa.daddr, 32'd20);
        wait_dreq("sw x10");
        check("jalr link", ifa.dwdata, 32'h150);
        wait_halt("ecall");
        check("ecall cause", 32'(cause_a), 32'h3);
        check("ecall pc", ifa.iaddr, 32'h20A);
        check("ecall ireq", 32'(ifa.ireq), 0);
`endif
        imem[64] = 32'h00700093; // ADDI x1,x0,7 so an unwanted store would write 14
        dwait = 100;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_dreq("stall sw");
        check("stall sw dwdata", ifa.dwdata, 32'd14);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort dreq", 32'(ifa.dreq), 0);
        check("abort dwe", 32'(ifa.dwe), 0);
        check("abort iaddr", ifa.iaddr, 32'h100);
        check("abort halted", 32'(halted_a), 0);
        check("abort mem", dmem[1], 32'd10);
        reset = 1'b1;
        @(negedge clk);
        check("refetch ireq", 32'(ifa.ireq), 1);
        check("refetch iaddr", ifa.iaddr, 32'h100);
        rst_b = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!retire_b && n < 20);
        check("rv32e addi retire", 32'(retire_b), 1);
        rcount = 0;
        repeat (10) begin
            @(negedge clk);
            rcount += int'(retire_b);
        end
        check("rv32e halted", 32'(halted_b), 1);
        check("rv32e cause", 32'(cause_b), 32'h1);
        check("rv32e no retire", 32'(rcount), 0);
        check("rv32e ireq", 32'(ifb.ireq), 0);
        check("rv32e pc", ifb.iaddr, 32'h4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/cpu_mc.md
# cpu_mc

Multi-cycle RV32I/RV32E core that replaces the single-cycle datapath as the design's processor block. Instruction and data memories are reached over request/valid handshakes, so they may insert any number of wait states. The core implements all RV32I integer, load/store, branch, JAL/JALR, LUI and AUIPC instructions. Illegal instructions and ECALL/EBREAK stop it in a sticky halt state.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded at reset.
- `NREGS`, default 32: architectural register count. Legal values are 32 (RV32I) or 16 (RV32E).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low; core is held in reset while 0.
- `iaddr`  out  32  instruction fetch address; always equals the PC.
- `ireq`  out  1  fetch request.
- `idata`  in  32  instruction word; sampled on the cycle where `ireq && ivalid`.
- `ivalid`  in  1  fetch response.
- `daddr`  out  32  data address (rs1 + imm).
- `dwdata`  out  32  store data, shifted into the addressed byte lanes.
- `dwe`  out  4  byte-lane write enables; all zero for loads.
- `dreq`  out  1  data request, for both loads and stores.
- `drdata`  in  32  load data; sampled on the cycle where `dreq && dvalid`.
- `dvalid`  in  1  data response or store acknowledge.
- `retire`  out  1  one-cycle pulse for each completed instruction.
- `halted`  out  1  sticky; cleared only by reset.
- `halt_cause`  out  2  01 = illegal instruction, 10 = misaligned access, 11 = ECALL/EBREAK, 00 = running.

## Operation
- States: FETCH, EXEC, MEM, HALT. Reset places the core in FETCH.
- FETCH
  - Drives `ireq` = 1 and `iaddr` = PC.
  - On `ivalid`, latches `idata` into the IR and moves to EXEC.
  - Without `ivalid`, stays in FETCH holding all outputs.
- EXEC: decodes the IR, runs the ALU, evaluates branches.
  - ALU, LUI, AUIPC, JAL, JALR, branch: writes rd (if any), updates PC, pulses `retire`, returns to FETCH.
  - Load/store: registers `daddr`, `dwdata` and `dwe`, then moves to MEM.
  - Illegal opcode, unsupported funct3/funct7 combination, or any register index ≥ NREGS: moves to HALT with cause 01. No register write, no `retire`.
  - ECALL/EBREAK: moves to HALT with cause 11.
- MEM
  - Holds `dreq` = 1 with `daddr`, `dwdata` and `dwe` stable until `dvalid` is seen.
  - On `dvalid`: a load writes rd with sign- or zero-extended lane data (LB/LH/LW/LBU/LHU). Then PC += 4, `retire` pulses, and the core returns to FETCH.
- HALT: `ireq` = `dreq` = 0 and `dwe` = 0; PC frozen.
- Register x0 reads as 0; writes to x0 are discarded.
- Next-PC rules:
  - Branch taken: PC + B-imm.
  - JAL: PC + J-imm.
  - JALR: (rs1 + I-imm) with bit 0 cleared.
  - JAL/JALR write PC + 4 to rd.
- All arithmetic is 32-bit modulo. Shift amount is operand[4:0]. SLT/SLTU use signed/unsigned compare.

## Timing
- Reset values:
  - PC = `iaddr` = RESET_VECTOR.
  - `ireq` = `dreq` = `retire` = `halted` = 0.
  - `dwe` = 0; `daddr` = `dwdata` = 0; `halt_cause` = 00.
  - All registers 0.
- `ireq` rises in the first cycle after `reset` is released.
- With zero-wait memories (`ivalid`/`dvalid` returned in the same cycle as the request):
  - ALU, branch and jump instructions take 2 cycles.
  - Loads and stores take 3 cycles.
  - Each wait cycle adds exactly one cycle.
- `retire` is asserted in the cycle the FSM leaves EXEC (non-memory instructions) or MEM (memory instructions).
- A load's rd write is visible to the next instruction's EXEC.
- `ivalid` while `ireq` = 0, and `dvalid` while `dreq` = 0, are ignored.
- Reset asserted mid-FETCH or mid-MEM abandons the access: all outputs return to reset values on that edge. The memories must tolerate a dropped request.

## Configuration
- `CPU_MC_MISALIGN_TRAP_EN` defined:
  - A misaligned access moves the core from EXEC to HALT with cause 10. No `dreq` is raised and no write occurs.
  - Misaligned means: halfword access with address bit 0 set, word access with address[1:0] ≠ 0, or a jump/branch target with bit 1 set.
- Macro undefined:
  - No check is made.
  - Word accesses force address[1:0] = 0 before the lane/offset logic.
  - Halfword accesses force address bit 0 = 0 before the lane/offset logic.
  - Jump and branch targets are used as computed.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants;
  - FSM state encoding;
  - halt-cause codes;
  - ALU function codes, keeping the existing 4-bit {funct7[5], funct3} encoding.
- One sub-module: `regfile_n`.
  - Parametrised by NREGS.
  - Two combinational read ports, one synchronous write port.
  - Synchronous active-low clear of all registers.
- Decode, ALU, immediate generation and load/store lane logic stay inline in `cpu_mc`.

## Test plan
- Reset with RESET_VECTOR = 32'h100, zero-wait memories → first `iaddr` = 32'h100; `retire` every 2 cycles through ADDI x1,x0,5 then ADD x2,x1,x1; x2 = 10.
- `dvalid` delayed 3 cycles on SW x2,4(x0) then LW x3,4(x0) → `daddr`, `dwdata` and `dwe` = 4'b1111 stable for 4 cycles; x3 = 10.
- SB at address 3 with rs2 = 32'h0000_00A5 → `dwe` = 4'b1000, `dwdata` = 32'hA500_0000; LB of the same byte → 32'hFFFF_FFA5, LBU → 32'h0000_00A5.
- BEQ taken/not taken, JAL and JALR (target 32'h203) → PC follows the next-PC rules, rd = PC + 4, JALR lands on 32'h202. With the macro defined, JALR to 32'h202 halts with cause 10.
- NREGS = 16, ADD x17,x1,x2 → `halted` = 1, `halt_cause` = 01, no `retire`, `ireq` = 0 until reset.
- Reset pulsed during a stalled MEM store → `dreq` = 0 and `dwe` = 0 on that edge; memory unchanged; refetch from RESET_VECTOR.
